// File: rtl/fetcher_pkg.sv
// Shared fetch-unit configuration: FSM state encoding and default reset PC.
package fetcher_pkg;

    // Fetch FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // driving a read request for pc
        ST_WAIT = 2'd1,   // request accepted, awaiting the response
        ST_HOLD = 2'd2    // instruction presented to the decoder
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetcher.sv
// Instruction fetcher: one outstanding word read at a time, presents each
// fetched word to the decoder, handles flush redirects and stale responses.
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        f_ok,
    input  logic [31:0] f_next_pc
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         discard;    // one in-flight response belongs to a flushed request
    logic         resp_pend;  // response arrived while stalled, held in resp_buf
    logic [31:0]  resp_buf;

    logic         req_fire;
    logic         resp_now;

    // Request is a decode of the state register; it is suppressed while
    // reset is held, while stalled, and while a stale response is still owed.
    assign mem_req_valid = rst_in && rdy_in && (state == ST_REQ) && !discard;
    assign mem_req_addr  = (rst_in && state == ST_REQ) ? pc : 32'h0;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_now      = mem_resp_valid || resp_pend;

    // Fetch FSM, PC, discard tracking and registered decoder outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            resp_pend  <= 1'b0;
            resp_buf   <= 32'h0;
            inst_valid <= 1'b0;
            inst_addr  <= 32'h0;
            inst_data  <= 32'h0;
        end else begin
            // The owed stale response retires whenever it shows up, even
            // while stalled; only a flushed request can be outstanding then.
            if (discard && mem_resp_valid)
                discard <= 1'b0;

            if (!rdy_in) begin
                // Frozen, but a live response must not be lost
                if (state == ST_WAIT && mem_resp_valid && !discard) begin
                    resp_pend <= 1'b1;
                    resp_buf  <= mem_resp_data;
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        if (rob_clear) begin
                            pc <= rob_clear_pc;
                            // accepted request is now stale; its response gets dropped
                            if (req_fire)
                                discard <= 1'b1;
                        end else if (req_fire) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (rob_clear) begin
                            pc        <= rob_clear_pc;
                            state     <= ST_REQ;
                            resp_pend <= 1'b0;
                            // a response arriving now is simply dropped; otherwise owe one
                            if (!resp_now)
                                discard <= 1'b1;
                        end else if (resp_now) begin
                            inst_valid <= 1'b1;
                            inst_addr  <= pc;
                            inst_data  <= resp_pend ? resp_buf : mem_resp_data;
                            resp_pend  <= 1'b0;
                            state      <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        // dropping inst_valid on every exit gives the mandatory
                        // gap, so a branch-to-self is seen as a new instruction
                        if (rob_clear) begin
                            pc         <= rob_clear_pc;
                            inst_valid <= 1'b0;
                            state      <= ST_REQ;
                        end else if (f_ok) begin
                            pc         <= f_next_pc;
                            inst_valid <= 1'b0;
                            state      <= ST_REQ;
                        end
                    end
                    default: begin
                        inst_valid <= 1'b0;
                        state      <= ST_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC loaded on reset.
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low: asserted low, clears state immediately, released synchronously with clk_in.
REQ-004 rdy_in  input  1  global ready; when low, all state holds.
REQ-005 rob_clear  input  1  pipeline flush request.
REQ-006 rob_clear_pc  input  32  redirect PC, valid with rob_clear.
REQ-007 mem_req_valid  output  1  instruction-word read request to memory controller.
REQ-008 mem_req_addr  output  32  word-aligned request address.
REQ-009 mem_req_ready  input  1  controller accepts the request this cycle.
REQ-010 mem_resp_valid  input  1  one-cycle pulse: read data valid.
REQ-011 mem_resp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  instruction presented to decoder.
REQ-013 inst_addr  output  32  PC of the presented instruction.
REQ-014 inst_data  output  32  presented instruction word.
REQ-015 f_ok  input  1  decoder consumed the presented instruction.
REQ-016 f_next_pc  input  32  next PC chosen by decoder, valid with f_ok.

Function
REQ-017 FSM states: REQ (drive request), WAIT (request accepted, awaiting response), HOLD (instruction presented).
REQ-018 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready go to WAIT; address stable until accepted.
REQ-019 WAIT: on mem_resp_valid latch inst_data<=mem_resp_data, inst_addr<=pc, go to HOLD.
REQ-020 HOLD: inst_valid=1, inst_addr/inst_data stable; on f_ok set pc<=f_next_pc, drop inst_valid next cycle, go to REQ.
REQ-021 inst_valid SHALL be low for at least one cycle between consecutive instructions, so a self-loop to the same PC is re-presented as a new instruction.
REQ-022 Minimum latency: request accepted in cycle N, response in N+1 -> inst_valid high in N+2; memory latency is arbitrary (>=1 cycle), exactly one response per accepted request.
REQ-023 rob_clear has priority over every other event in the same cycle: pc<=rob_clear_pc, inst_valid<=0, next state REQ.
REQ-024 rob_clear in WAIT: a discard flag SHALL be set; the next mem_resp_valid is dropped and the flag cleared; no new request is issued until that response arrives.
REQ-025 rob_clear coincident with mem_resp_valid in WAIT: response dropped, no discard flag set.
REQ-026 rob_clear coincident with f_ok in HOLD: f_next_pc ignored, rob_clear_pc used.
REQ-027 rob_clear in REQ with mem_req_ready same cycle: request counted as accepted, discard flag set.
REQ-028 rdy_in low: FSM, pc, outputs frozen; mem_resp_valid arriving while rdy_in low SHALL still be captured (or discarded per flag), never lost.
REQ-029 pc arithmetic 32-bit, no alignment checking; bits [1:0] of f_next_pc/rob_clear_pc passed through unchanged.

Reset
REQ-030 During rst_in low: pc=RESET_PC, state=REQ, discard flag=0, inst_valid=0, inst_addr=0, inst_data=0, mem_req_valid=0, mem_req_addr=0.
REQ-031 First request issued in the first rdy_in-high cycle after reset release; a response for a request issued before reset SHALL be ignored (discard flag set if reset asserted in WAIT? no: controller is reset together; no discard).

Structure
REQ-032 FSM state encoding (2-bit) and RESET_PC default belong in shared config.v alongside ROB/RS/LSB constants.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 Reset release, mem latency 1, f_ok immediately: request addr 0x0, inst_valid at cycle 2 with inst_addr=0x0; f_next_pc=0x4 -> next request addr 0x4.
REQ-035 Decoder stalls (f_ok low 5 cycles) -> inst_valid, inst_addr, inst_data constant for all 5 cycles, no new mem_req_valid.
REQ-036 rob_clear with rob_clear_pc=0x100 while WAIT, stale response data 0xDEADBEEF arrives 3 cycles later -> 0xDEADBEEF never presented; next request addr 0x100.
REQ-037 rob_clear and f_ok same cycle (f_next_pc=0x8, rob_clear_pc=0x40) -> next request addr 0x40.
REQ-038 JAL-to-self at 0x20 (f_next_pc=0x20) -> inst_valid low one cycle, then 0x20 presented again.
REQ-039 rdy_in low for 4 cycles spanning mem_resp_valid -> word captured, presented once rdy_in high, no duplicate request.
